// File: rtl/lane_fifo_arbiter_if.sv
// lane_fifo_arbiter_if
// Bundles the two lane push streams coming from the class demux, the merged
// valid/ready output stream and the per-lane flow-control flags.
//   slave  : the arbiter side (consumes pushes, drives out/flags)
//   master : the environment side (drives pushes and out_ready)
// Signals:
//   in0/push0, in1/push1           lane data and write strobes
//   out, out_valid, out_lane       merged registered output word and its source lane
//   out_ready                      consumer accepts out this cycle
//   almost_full0/1, empty0/1       decoded per-lane occupancy
//   error0/1                       sticky per-lane overflow flags
interface lane_fifo_arbiter_if #(
  parameter int MAIN_SIZE = 8
);
  logic [MAIN_SIZE-1:0] in0;
  logic                 push0;
  logic [MAIN_SIZE-1:0] in1;
  logic                 push1;
  logic [MAIN_SIZE-1:0] out;
  logic                 out_valid;
  logic                 out_lane;
  logic                 out_ready;
  logic                 almost_full0;
  logic                 almost_full1;
  logic                 empty0;
  logic                 empty1;
  logic                 error0;
  logic                 error1;

  modport slave (
    input  in0, push0, in1, push1, out_ready,
    output out, out_valid, out_lane,
    output almost_full0, almost_full1, empty0, empty1, error0, error1
  );

  modport master (
    output in0, push0, in1, push1, out_ready,
    input  out, out_valid, out_lane,
    input  almost_full0, almost_full1, empty0, empty1, error0, error1
  );
endinterface

// File: rtl/lane_fifo_arbiter.sv
// lane_fifo_arbiter
// Buffers the two demux lanes in independent FIFOs of 2**ADDR_SIZE entries
// and merges them onto one registered valid/ready output with round-robin
// arbitration. Each lane reports almost-full, empty and a sticky overflow
// error back to the demux.
// Ports:
//   clk    single clock, posedge
//   reset  asynchronous active-low reset
//   bus    lane_fifo_arbiter_if.slave (push streams, merged output, flags)
module lane_fifo_arbiter #(
  parameter int MAIN_SIZE = 8,
  parameter int ADDR_SIZE = 2,
  parameter int AFULL_TH  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  lane_fifo_arbiter_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_C = DEPTH[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0] AFULL_C = AFULL_TH[ADDR_SIZE:0];

  logic [1:0]           push;
  logic [1:0]           pop;
  logic [1:0]           empty;
  logic [1:0]           afull;
  logic [1:0]           err;
  logic [MAIN_SIZE-1:0] din  [2];
  logic [MAIN_SIZE-1:0] head [2];

  logic [MAIN_SIZE-1:0] out_q;
  logic                 out_valid_q;
  logic                 out_lane_q;
  logic                 rr_last_q;

  logic                 load_en;
  logic                 any_ne;
  logic                 sel;

  assign push    = {bus.push1, bus.push0};
  assign din[0]  = bus.in0;
  assign din[1]  = bus.in1;

  // ---- per-lane FIFO stage ----
  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [MAIN_SIZE-1:0] mem_q [DEPTH];
    logic [ADDR_SIZE-1:0] wr_q, rd_q;
    logic [ADDR_SIZE:0]   cnt_q, cnt_d;
    logic                 err_q;
    logic                 full;
    logic                 acc;
    logic                 ovf;

    assign full     = (cnt_q == DEPTH_C);
    assign empty[g] = (cnt_q == '0);
    assign afull[g] = (cnt_q >= AFULL_C);
    assign err[g]   = err_q;
    assign head[g]  = mem_q[rd_q];
    // A full lane still takes a push when the arbiter drains it in the same cycle.
    assign acc      = push[g] && (!full || pop[g]);
    assign ovf      = push[g] && full && !pop[g];

    always_comb begin
      cnt_d = cnt_q;
      if (acc && !pop[g])
        cnt_d = cnt_q + 1'b1;
      else if (!acc && pop[g])
        cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
        err_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        if (acc)    wr_q  <= wr_q + 1'b1;
        if (pop[g]) rd_q  <= rd_q + 1'b1;
        if (ovf)    err_q <= 1'b1;
      end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
      if (acc) mem_q[wr_q] <= din[g];
    end
  end

  // ---- arbitration / output register stage ----
  assign load_en = !out_valid_q || bus.out_ready;
  assign any_ne  = !(empty[0] && empty[1]);
  // On a tie serve the lane not served last; otherwise the only non-empty lane.
  assign sel     = (!empty[0] && !empty[1]) ? !rr_last_q : empty[0];
  assign pop     = (load_en && any_ne) ? (sel ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_lane_q  <= 1'b0;
      rr_last_q   <= 1'b1;
    end else if (load_en) begin
      if (any_ne) begin
        out_q       <= head[sel];
        out_lane_q  <= sel;
        out_valid_q <= 1'b1;
        rr_last_q   <= sel;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out          = out_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_lane     = out_lane_q;
  assign bus.empty0       = empty[0];
  assign bus.empty1       = empty[1];
  assign bus.almost_full0 = afull[0];
  assign bus.almost_full1 = afull[1];
  assign bus.error0       = err[0];
  assign bus.error1       = err[1];

endmodule

// File: tb/tb_lane_fifo_arbiter.sv
module tb_lane_fifo_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [8:0] sb [$];
  logic [8:0] exp_w;

  always #5 clk = ~clk;

  lane_fifo_arbiter_if #(.MAIN_SIZE(8)) bus ();

  lane_fifo_arbiter #(.MAIN_SIZE(8), .ADDR_SIZE(2), .AFULL_TH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(sb.size() == 0 && !bus.out_valid), 32'd1);
  endtask

  // Every word the consumer takes must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_extra observed=%0h expected=none", {bus.out_lane, bus.out});
      end
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        assert ({bus.out_lane, bus.out} === exp_w) else begin
          errors++;
          $error("FAIL sb_word observed=%0h expected=%0h", {bus.out_lane, bus.out}, exp_w);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.in0 = '0; bus.push0 = 1'b0;
    bus.in1 = '0; bus.push1 = 1'b0;
    bus.out_ready = 1'b0;

    // Reset held: pushes have no effect
    for (int i = 0; i < 3; i++) begin
      bus.push0 = 1'b1; bus.in0 = 8'(i + 1);
      bus.push1 = 1'b1; bus.in1 = 8'(i + 9);
      tick();
      chk("rst_valid",  32'(bus.out_valid), 32'd0);
      chk("rst_out",    32'(bus.out),       32'd0);
      chk("rst_empty0", 32'(bus.empty0),    32'd1);
      chk("rst_empty1", 32'(bus.empty1),    32'd1);
      chk("rst_err0",   32'(bus.error0),    32'd0);
      chk("rst_err1",   32'(bus.error1),    32'd0);
    end
    bus.push0 = 1'b0; bus.push1 = 1'b0;
    reset = 1'b1;
    tick();
    chk("idle_af0", 32'(bus.almost_full0), 32'd0);

    // Latency and tie-break
    bus.out_ready = 1'b1;
    bus.push0 = 1'b1; bus.in0 = 8'hFF;
    bus.push1 = 1'b1; bus.in1 = 8'hDD;
    sb.push_back({1'b0, 8'hFF});
    sb.push_back({1'b1, 8'hDD});
    tick();
    bus.push0 = 1'b0; bus.push1 = 1'b0;
    chk("lat_n_valid", 32'(bus.out_valid), 32'd0);
    chk("lat_n_empty0", 32'(bus.empty0), 32'd0);
    tick();
    chk("lat_n1_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_n1_out",   32'(bus.out),       32'hFF);
    chk("lat_n1_lane",  32'(bus.out_lane),  32'd0);
    tick();
    chk("lat_n2_out",   32'(bus.out),       32'hDD);
    chk("lat_n2_lane",  32'(bus.out_lane),  32'd1);
    tick();
    chk("lat_n3_valid", 32'(bus.out_valid), 32'd0);

    // Round-robin under load
    begin
      logic [7:0] l0 [4];
      logic [7:0] l1 [4];
      l0 = '{8'hEE, 8'hAA, 8'hEE, 8'hAA};
      l1 = '{8'hCC, 8'h99, 8'h88, 8'h77};
      for (int i = 0; i < 4; i++) begin
        bus.push0 = 1'b1; bus.in0 = l0[i];
        bus.push1 = 1'b1; bus.in1 = l1[i];
        sb.push_back({1'b0, l0[i]});
        sb.push_back({1'b1, l1[i]});
        tick();
      end
    end
    bus.push0 = 1'b0; bus.push1 = 1'b0;
    drain("rr_drain");
    chk("rr_empty0", 32'(bus.empty0), 32'd1);
    chk("rr_empty1", 32'(bus.empty1), 32'd1);

    // Backpressure and almost-full
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.push0 = 1'b1; bus.in0 = 8'(i);
      sb.push_back({1'b0, 8'(i)});
      tick();
      if (i == 3) chk("bp_af0_cnt2", 32'(bus.almost_full0), 32'd0);
    end
    bus.push0 = 1'b0;
    chk("bp_af0",    32'(bus.almost_full0), 32'd1);
    chk("bp_empty0", 32'(bus.empty0),       32'd0);
    chk("bp_valid",  32'(bus.out_valid),    32'd1);
    chk("bp_out",    32'(bus.out),          32'h01);
    tick(); tick();
    chk("bp_hold",   32'(bus.out),          32'h01);
    bus.out_ready = 1'b1;
    drain("bp_drain");
    chk("bp_af0_clr", 32'(bus.almost_full0), 32'd0);

    // Overflow on lane 1
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.push1 = 1'b1; bus.in1 = 8'(8'h10 + i);
      if (i < 5) sb.push_back({1'b1, 8'(8'h10 + i)});
      tick();
      if (i == 4) chk("ovf_err1_pre", 32'(bus.error1), 32'd0);
    end
    bus.push1 = 1'b0;
    chk("ovf_err1",   32'(bus.error1),       32'd1);
    chk("ovf_err0",   32'(bus.error0),       32'd0);
    chk("ovf_af1",    32'(bus.almost_full1), 32'd1);
    tick();
    chk("ovf_sticky", 32'(bus.error1),       32'd1);
    bus.out_ready = 1'b1;
    drain("ovf_drain");
    chk("ovf_sticky_drained", 32'(bus.error1), 32'd1);

    // Mid-operation async reset with data stored
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.push0 = 1'b1; bus.in0 = 8'(8'h31 + i);
      tick();
    end
    bus.push0 = 1'b0;
    chk("mid_pre_valid", 32'(bus.out_valid), 32'd1);
    reset = 1'b0;
    #2;
    chk("mid_valid",  32'(bus.out_valid), 32'd0);
    chk("mid_out",    32'(bus.out),       32'd0);
    chk("mid_empty0", 32'(bus.empty0),    32'd1);
    chk("mid_err1",   32'(bus.error1),    32'd0);
    sb.delete();
    tick();
    reset = 1'b1;
    tick();
    chk("mid_post_valid", 32'(bus.out_valid), 32'd0);

    // Full lane 0 with push and pop in the same cycle
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.push0 = 1'b1; bus.in0 = 8'(8'h21 + i);
      sb.push_back({1'b0, 8'(8'h21 + i)});
      tick();
    end
    chk("full_err0_pre", 32'(bus.error0), 32'd0);
    bus.out_ready = 1'b1;
    bus.push0 = 1'b1; bus.in0 = 8'h5A;
    sb.push_back({1'b0, 8'h5A});
    tick();
    bus.push0 = 1'b0;
    bus.out_ready = 1'b0;
    chk("full_err0", 32'(bus.error0),       32'd0);
    chk("full_af0",  32'(bus.almost_full0), 32'd1);
    chk("full_out",  32'(bus.out),          32'h22);
    bus.out_ready = 1'b1;
    drain("full_drain");
    chk("full_err0_end", 32'(bus.error0), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lane_fifo_arbiter.md
Name: lane_fifo_arbiter

Overview:
- Downstream stage of the 10-bit class demux: takes its two 8-bit lane outputs (class 0 -> lane 0, class 2 -> lane 1) as push streams.
- Buffers each lane in its own FIFO, then merges both lanes onto one output port with round-robin arbitration and valid/ready backpressure.
- Returns per-lane almost-full and sticky overflow-error flags to the demux for flow control.

Parameters:
- MAIN_SIZE, 8: data width of each lane and of the merged output.
- ADDR_SIZE, 2: FIFO address width; depth = 2**ADDR_SIZE entries per lane.
- AFULL_TH, 3: almost_full asserts when the lane count >= AFULL_TH.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- in0  input  MAIN_SIZE  lane 0 data from demux.
- push0  input  1  write strobe for lane 0.
- in1  input  MAIN_SIZE  lane 1 data from demux.
- push1  input  1  write strobe for lane 1.
- out  output  MAIN_SIZE  merged data, registered.
- out_valid  output  1  out holds a valid word.
- out_lane  output  1  source lane of the current out word.
- out_ready  input  1  consumer accepts out this cycle.
- almost_full0, almost_full1  output  1  lane count >= AFULL_TH.
- empty0, empty1  output  1  lane count == 0.
- error0, error1  output  1  sticky overflow flag per lane.

Behaviour:
- Reset (reset=0, async): all FIFO pointers and counts = 0; out = 0; out_valid = 0; out_lane = 0; error0/1 = 0; almost_full0/1 = 0; empty0/1 = 1; rr_last = 1, so lane 0 wins the first tie.
- Mid-operation reset: all stored data is discarded and every output returns to its reset value immediately, without waiting for a clock edge.
- Each FIFO:
  - Count width ADDR_SIZE+1; read/write pointers ADDR_SIZE bits, wrapping modulo depth.
  - Push accepted when count < depth, or when count == depth and the same lane is popped in that cycle (count unchanged).
  - Push onto a full lane with no same-cycle pop: data dropped, pointers unchanged, errorN set to 1 and held until reset.
- almost_fullN and emptyN decode the registered count; they change on the edge that updates the count.
- Output register load:
  - load_en = !out_valid || out_ready.
  - If load_en and at least one lane is non-empty: pop the selected lane, out <= head word, out_lane <= lane, out_valid <= 1.
  - If load_en and both lanes are empty: out_valid <= 0; out and out_lane keep their previous values.
  - If out_valid && !out_ready: out, out_lane and out_valid are held; no pop occurs.
- Arbitration:
  - Both lanes non-empty: select !rr_last.
  - Only one non-empty: select that lane.
  - rr_last updates to the selected lane on every pop.
- Latency: a word pushed at edge N into an empty lane with the output register free appears on out with out_valid=1 after edge N+1.
- Throughput: one word per cycle while out_ready=1.
- Underflow cannot occur: pops happen only from non-empty lanes.
- Simultaneous push and pop on the same lane in one cycle: both occur; count unchanged.

Test Plan:
- Reset check: hold reset=0, toggle pushes -> out_valid=0, empty0=empty1=1, error0=error1=0, out=0 throughout.
- Latency and tie-break: out_ready=1, one cycle with push0 in0=0xFF and push1 in1=0xDD together -> out=0xFF lane0 after edge N+1, then out=0xDD lane1 after edge N+2, then out_valid=0.
- Round-robin under load: out_ready=1, four cycles pushing both lanes (lane0 0xEE,0xAA,0xEE,0xAA; lane1 0xCC,0x99,0x88,0x77) -> out sequence alternates lanes 0,1,0,1,... with each lane's words in order.
- Backpressure and almost-full: out_ready=0, push lane0 0x01..0x04 -> almost_full0=1 after the third stored word, empty0=0, out=0x01 held stable with out_valid=1; then out_ready=1 -> 0x01..0x04 drain in order.
- Overflow: out_ready=0, push lane1 six times (0x10..0x15) -> out register plus FIFO hold 0x10..0x14, 0x15 dropped, error1=1 sticky; error0 stays 0; reset clears error1.
- Full lane, push plus pop in the same cycle: lane0 full, out_ready=1, push0 0x5A -> accepted, count stays 4, error0 stays 0, and 0x5A later drains in order.
